// File: rtl/alu_core_if.sv
// Execute-stage ALU bus: operand/function request and registered result/flags.
// The master drives the operation; the ALU (slave) returns the result a cycle later.
interface alu_core_if;
  logic        en;
  logic [31:0] i1;
  logic [31:0] i2;
  logic [4:0]  shamt;
  logic [3:0]  func;
  logic [31:0] o;
  logic        zero;
  logic        ovf;
  logic        out_valid;

  modport master (
    output en, i1, i2, shamt, func,
    input  o, zero, ovf, out_valid
  );

  modport slave (
    input  en, i1, i2, shamt, func,
    output o, zero, ovf, out_valid
  );
endinterface

// File: rtl/alu_core.sv
// 32-bit integer ALU: combinational result/flags captured by one register stage.
// Outputs hold when en is low; asynchronous reset forces o=0, zero=1, ovf=0, out_valid=0.
module alu_core (
  input  logic       clk,
  input  logic       rst_n,
  alu_core_if.slave  bus
);

  typedef enum logic [3:0] {
    F_ADD  = 4'd0,  F_SUB  = 4'd1,  F_AND  = 4'd2,  F_OR   = 4'd3,
    F_XOR  = 4'd4,  F_NOR  = 4'd5,  F_SLL  = 4'd6,  F_SRL  = 4'd7,
    F_SRA  = 4'd8,  F_SLT  = 4'd9,  F_SLTU = 4'd10, F_LUI  = 4'd11,
    F_SLLV = 4'd12, F_SRLV = 4'd13, F_SRAV = 4'd14, F_PASS = 4'd15
  } func_e;

  typedef struct packed {
    logic [31:0] o;
    logic        zero;
    logic        ovf;
  } alu_rsp_t;

  localparam alu_rsp_t RSP_RST = '{o: 32'h0, zero: 1'b1, ovf: 1'b0};

  logic [31:0] a, b;
  logic [31:0] sum, diff;
  logic [4:0]  vsh;
  logic        add_ovf, sub_ovf;
  alu_rsp_t    rsp_d, rsp_q;
  logic        vld_d, vld_q;

  assign a     = bus.i1;
  assign b     = bus.i2;
  assign sum   = a + b;
  assign diff  = a - b;
  assign vsh   = a[4:0];
  assign vld_d = bus.en;

  // Signed overflow from operand/result sign bits only.
  assign add_ovf = (a[31] == b[31]) && (sum[31]  != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

  always_comb begin
    rsp_d = '0;
    unique case (func_e'(bus.func))
      F_ADD:  begin rsp_d.o = sum;  rsp_d.ovf = add_ovf; end
      F_SUB:  begin rsp_d.o = diff; rsp_d.ovf = sub_ovf; end
      F_AND:  rsp_d.o = a & b;
      F_OR:   rsp_d.o = a | b;
      F_XOR:  rsp_d.o = a ^ b;
      F_NOR:  rsp_d.o = ~(a | b);
      F_SLL:  rsp_d.o = b << bus.shamt;
      F_SRL:  rsp_d.o = b >> bus.shamt;
      F_SRA:  rsp_d.o = $unsigned($signed(b) >>> bus.shamt);
      F_SLT:  rsp_d.o = {31'h0, $signed(a) < $signed(b)};
      F_SLTU: rsp_d.o = {31'h0, a < b};
      F_LUI:  rsp_d.o = {b[15:0], 16'h0000};
      F_SLLV: rsp_d.o = b << vsh;
      F_SRLV: rsp_d.o = b >> vsh;
      F_SRAV: rsp_d.o = $unsigned($signed(b) >>> vsh);
      F_PASS: rsp_d.o = a;
    endcase
    rsp_d.zero = (rsp_d.o == 32'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= RSP_RST;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (vld_d) rsp_q <= rsp_d;
    end
  end

  assign bus.o         = rsp_q.o;
  assign bus.zero      = rsp_q.zero;
  assign bus.ovf       = rsp_q.ovf;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: each op checks o/ovf/zero/out_valid against
// hand-computed values, then hold, mid-cycle stability and async reset behaviour.
module tb_alu_core;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_core_if bus();

  alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] eo, input logic eovf,
                         input logic ez, input logic evld);
    chk({tag, ".o"},    bus.o,                 eo);
    chk({tag, ".ovf"},  {31'h0, bus.ovf},       {31'h0, eovf});
    chk({tag, ".zero"}, {31'h0, bus.zero},      {31'h0, ez});
    chk({tag, ".vld"},  {31'h0, bus.out_valid}, {31'h0, evld});
  endtask

  task automatic drive(input logic e, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    bus.en = e; bus.func = f; bus.i1 = a; bus.i2 = b; bus.shamt = sh;
  endtask

  task automatic op(input string tag, input logic [3:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] sh,
                    input logic [31:0] eo, input logic eovf);
    @(negedge clk);
    drive(1'b1, f, a, b, sh);
    @(posedge clk);
    #1;
    chk_out(tag, eo, eovf, eo == 32'h0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b0;
    #12;
    chk_out("rst", 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back ops, i1=45 i2=61
    op("add",  4'd0, 32'd45, 32'd61, 5'd0, 32'h0000006A, 1'b0);
    op("sub",  4'd1, 32'd45, 32'd61, 5'd0, 32'hFFFFFFF0, 1'b0);
    op("and",  4'd2, 32'd45, 32'd61, 5'd0, 32'h0000002D, 1'b0);
    op("nor",  4'd5, 32'd45, 32'd61, 5'd0, 32'hFFFFFFC2, 1'b0);
    op("or",   4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'hF0F00F0F, 1'b0);
    op("xor",  4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'hF0F00F0F, 1'b0);
    // shifts; shamt must be ignored by non-immediate shifts
    op("sll",  4'd6, 32'h0, 32'd61, 5'd7, 32'h00001E80, 1'b0);
    op("srl",  4'd7, 32'h0, 32'hA0341BB4, 5'd3, 32'h14068376, 1'b0);
    op("sra",  4'd8, 32'h0, 32'hA0341BB4, 5'd3, 32'hF4068376, 1'b0);
    op("srav", 4'd14, 32'd3, 32'hA0341BB4, 5'd0, 32'hF4068376, 1'b0);
    op("srav_hi", 4'd14, 32'hFFFF_FFE3, 32'hA0341BB4, 5'd9, 32'hF4068376, 1'b0);
    op("srlv", 4'd13, 32'd4, 32'h8000_0000, 5'd1, 32'h08000000, 1'b0);
    op("sllv", 4'd12, 32'd31, 32'h0000_0003, 5'd0, 32'h80000000, 1'b0);
    op("sll0", 4'd6, 32'h0, 32'h8765_4321, 5'd0, 32'h87654321, 1'b0);
    op("sra0", 4'd8, 32'h0, 32'h8765_4321, 5'd0, 32'h87654321, 1'b0);
    op("sra31", 4'd8, 32'h0, 32'h8000_0000, 5'd31, 32'hFFFFFFFF, 1'b0);
    // overflow
    op("add_ov", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h80000000, 1'b1);
    op("add_nov", 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h00000000, 1'b0);
    op("add_ovn", 4'd0, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'h00000000, 1'b1);
    op("sub_ov", 4'd1, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFFFFFF, 1'b1);
    op("sub_ovp", 4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h80000000, 1'b1);
    op("sub_z", 4'd1, 32'd5, 32'd5, 5'd0, 32'h00000000, 1'b0);
    op("sub_nov", 4'd1, 32'd5, 32'hFFFF_FFFF, 5'd0, 32'h00000006, 1'b0);
    op("and_ovx", 4'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 32'h7FFFFFFF, 1'b0);
    // compares, lui, pass
    op("slt",  4'd9,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'h00000001, 1'b0);
    op("sltu", 4'd10, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h00000000, 1'b0);
    op("sltu1", 4'd10, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'h00000001, 1'b0);
    op("slt0", 4'd9,  32'd7, 32'hFFFF_FFF0, 5'd0, 32'h00000000, 1'b0);
    op("lui",  4'd11, 32'hDEAD_BEEF, 32'hABCD_1234, 5'd0, 32'h12340000, 1'b0);
    op("pass", 4'd15, 32'hCAFE_F00D, 32'h1111_1111, 5'd5, 32'hCAFEF00D, 1'b0);

    // overflow result held for hold test
    op("pre_hold", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h80000000, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'd1, 32'd5, 32'd5, 5'd0);
    @(posedge clk);
    #1;
    chk_out("hold", 32'h80000000, 1'b1, 1'b0, 1'b0);

    // operand/func changes between edges must not reach the outputs
    op("mid_pre", 4'd2, 32'h0000_00FF, 32'h0000_0F0F, 5'd0, 32'h0000000F, 1'b0);
    #2;
    drive(1'b1, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    #1;
    chk_out("midcyc", 32'h0000000F, 1'b0, 1'b0, 1'b1);

    // async reset mid-cycle, held across an enabled edge
    op("pre_rst", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h80000000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd15, 32'h1234_5678, 32'h0, 5'd0);
    @(posedge clk);
    #1;
    chk_out("rst_hold", 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst", 4'd15, 32'h1234_5678, 32'h0, 5'd0, 32'h12345678, 1'b0);

    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_core.md
# alu_core

32-bit clocked integer ALU for the 32-bit processor datapath. It performs add/subtract, bitwise logic, immediate and variable shifts, set-less-than and load-upper-immediate. Each operation is selected by a 4-bit `func` code. The result and status flags are registered, with one-cycle latency, so the block sits directly in the execute stage.

## Interface

- No parameters. Data width is fixed at 32 bits.
- One clock; reset is asynchronous and active-low.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `en` input, 1 bit: operation enable; the operands are sampled on a rising `clk` edge when `en`=1.
- `i1` input, 32 bits: operand A (rs).
- `i2` input, 32 bits: operand B (rt); this is also the shift source.
- `shamt` input, 5 bits: immediate shift amount.
- `func` input, 4 bits: operation select.
- `o` output, 32 bits: registered result.
- `zero` output, 1 bit: registered flag, 1 when the result is 0.
- `ovf` output, 1 bit: registered signed-overflow flag (ADD/SUB only).
- `out_valid` output, 1 bit: 1 for the cycle after an enabled operation.

## Operation

- func 0 ADD: i1 + i2, modulo 2^32.
- func 1 SUB: i1 − i2, modulo 2^32.
- func 2 AND: i1 & i2.
- func 3 OR: i1 | i2.
- func 4 XOR: i1 ^ i2.
- func 5 NOR: ~(i1 | i2).
- func 6 SLL: i2 << shamt, zero-filled.
- func 7 SRL: i2 >> shamt, logical, zero-filled.
- func 8 SRA: i2 >>> shamt, arithmetic, sign-filled from i2[31].
- func 9 SLT: 1 if $signed(i1) < $signed(i2), else 0.
- func 10 SLTU: 1 if i1 < i2 unsigned, else 0.
- func 11 LUI: {i2[15:0], 16'h0000}.
- func 12 SLLV: i2 << i1[4:0].
- func 13 SRLV: i2 >> i1[4:0], logical.
- func 14 SRAV: i2 >>> i1[4:0], arithmetic.
- func 15 PASS: i1.
- Shifts by 0 return i2 unchanged. Only the low 5 bits of i1 matter for variable shifts.
- `ovf` rules:
  - ADD: set when the operands have the same sign and the result sign differs.
  - SUB: set when the operands have different signs and the result sign differs from i1.
  - All other funcs: 0.
- The result is still written when `ovf` is set; no trap is raised.
- `zero` = (result == 0), computed on the registered result value for every func.
- `shamt` is ignored by all funcs except 6, 7 and 8.

## Timing

- Combinational result plus a single register stage: latency is 1 cycle, throughput is 1 operation per cycle.
- Rising edge with `en`=1: `o`, `zero` and `ovf` load the new result; `out_valid` goes to 1.
- Rising edge with `en`=0: `o`, `zero` and `ovf` hold their previous values; `out_valid` goes to 0.
- Reset (`rst_n`=0) takes effect immediately, independent of `clk`:
  - `o` = 0, `zero` = 1, `ovf` = 0, `out_valid` = 0.
  - All outputs hold these values while `rst_n` is low.
- Reset asserted during an operation discards that result.
- The first enabled edge after `rst_n` rises loads normally.
- Operand or `func` changes between edges have no effect on the outputs.
- No X propagation: every func code is defined.

## Test plan

- Reset, then with en=1, i1=45, i2=61, step funcs 0, 1, 2, 5 on consecutive edges. Required `o` sequence:
  - ADD: 0x0000006A, ovf=0.
  - SUB: 0xFFFFFFF0.
  - AND: 0x0000002D.
  - NOR: 0xFFFFFFC2.
  - `out_valid` stays 1 for each cycle.
- Shifts:
  - i2=61, shamt=7, func 6 → o=0x00001E80.
  - i2=0xA0341BB4, shamt=3, func 7 → o=0x14068376.
  - Same i2 and shamt, func 8 → o=0xF4068376.
  - Same i2, i1=3, func 14 → o=0xF4068376.
- Overflow:
  - ADD 0x7FFFFFFF + 1 → o=0x80000000, ovf=1.
  - SUB 0x80000000 − 1 → o=0x7FFFFFFF, ovf=1.
  - SUB 5 − 5 → o=0, zero=1, ovf=0.
- Compare:
  - i1=0xFFFFFFFF, i2=1, func 9 → o=1.
  - Same operands, func 10 → o=0.
  - i2=0x00001234, func 11 → o=0x12340000.
- Hold and reset:
  - Drop en with new operands applied → o, zero and ovf unchanged; out_valid=0 on the next edge.
  - Assert rst_n=0 mid-cycle → o=0, zero=1, ovf=0, out_valid=0 immediately, before the next clk edge.
